// File: rtl/reel_spin_scheduler.sv
// Three-reel spin sequencer stepped on the vsync frame tick: free spin, then reels stop one by one on latched sprites.
// Optional build macro SKIP_STOP_EN: a start_spin rise while spinning snaps unstopped reels to their targets.
module reel_spin_scheduler #(
    parameter int NUM_SPRITES    = 7,
    parameter int SPRITE_H       = 64,
    parameter int SPEED          = 8,
    parameter int SPIN_FRAMES    = 60,
    parameter int STAGGER_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       start_spin,
    input  logic [2:0] final1_sprite,
    input  logic [2:0] final2_sprite,
    input  logic [2:0] final3_sprite,
    output logic [8:0] reel1_offset,
    output logic [8:0] reel2_offset,
    output logic [8:0] reel3_offset,
    output logic [2:0] reel_stopped,
    output logic       busy,
    output logic       done
);

    localparam int STRIP   = NUM_SPRITES * SPRITE_H;
    localparam int CNT_MAX = (SPIN_FRAMES > STAGGER_FRAMES) ? SPIN_FRAMES : STAGGER_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SPIN_END = CNT_W'(SPIN_FRAMES - 1);
    localparam logic [CNT_W-1:0] STAGGER  = CNT_W'(STAGGER_FRAMES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SPIN  = 3'd1,
        STOP1 = 3'd2,
        STOP2 = 3'd3,
        STOP3 = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t           state_q;
    logic [8:0]       off_q [3];
    logic [8:0]       tgt_q [3];
    logic [8:0]       off_adv [3];
    logic [2:0]       stopped_q;
    logic             busy_q;
    logic             done_q;
    logic             vsync_q;
    logic             start_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tick;
    logic             rise;

    function automatic logic [8:0] advance(input logic [8:0] off);
        logic [9:0] sum;
        sum = {1'b0, off} + 10'(SPEED);
        if (sum >= 10'(STRIP)) sum = sum - 10'(STRIP);
        return 9'(sum);
    endfunction

    // Out-of-range sprite requests land on sprite 0.
    function automatic logic [8:0] target_of(input logic [2:0] f);
        if (int'(f) >= NUM_SPRITES) return 9'd0;
        return 9'(int'(f) * SPRITE_H);
    endfunction

    assign tick = vsync_q & ~vsync;
    assign rise = start_spin & ~start_q;

    always_comb begin
        for (int k = 0; k < 3; k++) off_adv[k] = advance(off_q[k]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            for (int k = 0; k < 3; k++) begin
                off_q[k] <= '0;
                tgt_q[k] <= '0;
            end
            stopped_q <= 3'b111;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            vsync_q   <= 1'b1;
            start_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            vsync_q <= vsync;
            start_q <= start_spin;
            done_q  <= 1'b0;
`ifdef SKIP_STOP_EN
            if (rise && (state_q inside {SPIN, STOP1, STOP2, STOP3})) begin
                for (int k = 0; k < 3; k++) begin
                    if (!stopped_q[k]) off_q[k] <= tgt_q[k];
                end
                stopped_q <= 3'b111;
                state_q   <= DONE;
                done_q    <= 1'b1;
            end else
`endif
            begin
                // Stopped reels hold; in IDLE and DONE all three are stopped.
                if (tick) begin
                    for (int k = 0; k < 3; k++) begin
                        if (!stopped_q[k]) off_q[k] <= off_adv[k];
                    end
                end
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            tgt_q[0]  <= target_of(final1_sprite);
                            tgt_q[1]  <= target_of(final2_sprite);
                            tgt_q[2]  <= target_of(final3_sprite);
                            cnt_q     <= '0;
                            stopped_q <= 3'b000;
                            busy_q    <= 1'b1;
                            state_q   <= SPIN;
                        end
                    end
                    SPIN: begin
                        if (tick) begin
                            if (cnt_q == SPIN_END) begin
                                cnt_q   <= '0;
                                state_q <= STOP1;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    STOP1: begin
                        if (tick && off_adv[0] == tgt_q[0]) begin
                            stopped_q[0] <= 1'b1;
                            cnt_q        <= '0;
                            state_q      <= STOP2;
                        end
                    end
                    STOP2: begin
                        if (tick) begin
                            if (cnt_q < STAGGER) begin
                                cnt_q <= cnt_q + 1'b1;
                            end else if (off_adv[1] == tgt_q[1]) begin
                                stopped_q[1] <= 1'b1;
                                cnt_q        <= '0;
                                state_q      <= STOP3;
                            end
                        end
                    end
                    STOP3: begin
                        if (tick) begin
                            if (cnt_q < STAGGER) begin
                                cnt_q <= cnt_q + 1'b1;
                            end else if (off_adv[2] == tgt_q[2]) begin
                                stopped_q[2] <= 1'b1;
                                cnt_q        <= '0;
                                done_q       <= 1'b1;
                                state_q      <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign reel1_offset = off_q[0];
    assign reel2_offset = off_q[1];
    assign reel3_offset = off_q[2];
    assign reel_stopped = stopped_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_reel_spin_scheduler.sv
// Directed bench for reel_spin_scheduler; a second instance with SPIN_FRAMES=56 covers the full-revolution seek.
module tb_reel_spin_scheduler;

    logic       clk = 1'b0;
    logic       reset, vsync, start_spin;
    logic [2:0] f1, f2, f3;
    logic [2:0] g1, g2, g3;
    logic [8:0] r1, r2, r3, b_r1, b_r2, b_r3;
    logic [2:0] stopped, b_stopped;
    logic       busy, done, b_busy, b_done;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int b_done_cnt = 0;

    always #5 clk = ~clk;

    reel_spin_scheduler dut (
        .clk(clk), .reset(reset), .vsync(vsync), .start_spin(start_spin),
        .final1_sprite(f1), .final2_sprite(f2), .final3_sprite(f3),
        .reel1_offset(r1), .reel2_offset(r2), .reel3_offset(r3),
        .reel_stopped(stopped), .busy(busy), .done(done)
    );

    reel_spin_scheduler #(.SPIN_FRAMES(56)) dut56 (
        .clk(clk), .reset(reset), .vsync(vsync), .start_spin(start_spin),
        .final1_sprite(g1), .final2_sprite(g2), .final3_sprite(g3),
        .reel1_offset(b_r1), .reel2_offset(b_r2), .reel3_offset(b_r3),
        .reel_stopped(b_stopped), .busy(b_busy), .done(b_done)
    );

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (b_done === 1'b1) b_done_cnt++;
    end

    // One frame: vsync low for 10 cycles, then high for 10; starts and ends on a negedge.
    task automatic frame();
        vsync = 1'b0;
        repeat (10) @(negedge clk);
        vsync = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic start(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        f1 = a; f2 = b; f3 = c;
        start_spin = 1'b0;
        @(negedge clk);
        start_spin = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; start_spin = 1'b0; vsync = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        g1 = 3'd0; g2 = 3'd0; g3 = 3'd0;
        f1 = 3'd0; f2 = 3'd0; f3 = 3'd0;
        do_reset();
        n_cmp++; if ({r1, r2, r3} !== 27'd0) begin n_bad++; $display("FAIL reset_offsets: got %0d/%0d/%0d want 0/0/0", r1, r2, r3); end
        n_cmp++; if (stopped !== 3'b111) begin n_bad++; $display("FAIL reset_stopped: got %b want 111", stopped); end
        n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_done: got %b want 00", {busy, done}); end
    endtask

    task automatic test_full_spin();
        int d0;
        d0 = done_cnt;
        start(3'd3, 3'd5, 3'd0);
        n_cmp++; if ({busy, stopped} !== 4'b1000) begin n_bad++; $display("FAIL spin_start: got busy/stopped %b want 1000", {busy, stopped}); end
        for (int t = 1; t <= 224; t++) begin
            frame();
            if (t == 1) begin
                n_cmp++; if (r1 !== 9'd8) begin n_bad++; $display("FAIL one_step_per_pulse: got %0d want 8", r1); end
            end
            if (t == 56) begin
                n_cmp++; if ({b_stopped, b_r1} !== {3'b000, 9'd0}) begin n_bad++; $display("FAIL rev_stop1_entry: got %b/%0d want 000/0", b_stopped, b_r1); end
            end
            if (t == 60) begin
                n_cmp++; if ({stopped, r1} !== {3'b000, 9'd32}) begin n_bad++; $display("FAIL stop1_entry: got %b/%0d want 000/32", stopped, r1); end
            end
            if (t == 79) begin
                n_cmp++; if ({stopped, r1} !== {3'b000, 9'd184}) begin n_bad++; $display("FAIL reel1_pre_stop: got %b/%0d want 000/184", stopped, r1); end
            end
            if (t == 80) begin
                n_cmp++; if ({stopped, r1} !== {3'b001, 9'd192}) begin n_bad++; $display("FAIL reel1_stop: got %b/%0d want 001/192", stopped, r1); end
            end
            if (t == 110) begin
                n_cmp++; if ({stopped, r2} !== {3'b001, 9'd432}) begin n_bad++; $display("FAIL stagger_no_compare: got %b/%0d want 001/432", stopped, r2); end
            end
            if (t == 111) begin
                n_cmp++; if (b_stopped !== 3'b000) begin n_bad++; $display("FAIL rev_pre_stop: got %b want 000", b_stopped); end
            end
            if (t == 112) begin
                n_cmp++; if ({b_stopped, b_r1} !== {3'b001, 9'd0}) begin n_bad++; $display("FAIL rev_stop: got %b/%0d want 001/0", b_stopped, b_r1); end
            end
            if (t == 152) begin
                n_cmp++; if ({stopped, r2, r3} !== {3'b011, 9'd320, 9'd320}) begin n_bad++; $display("FAIL reel2_stop: got %b/%0d/%0d want 011/320/320", stopped, r2, r3); end
            end
            if (t == 223) begin
                n_cmp++; if ({busy, stopped} !== 4'b1011) begin n_bad++; $display("FAIL reel3_pre_stop: got %b want 1011", {busy, stopped}); end
            end
            if (t == 224) begin
                n_cmp++; if ({stopped, r1, r2, r3} !== {3'b111, 9'd192, 9'd320, 9'd0}) begin n_bad++; $display("FAIL final_offsets: got %b/%0d/%0d/%0d want 111/192/320/0", stopped, r1, r2, r3); end
            end
        end
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_after: got %b want 0", busy); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL done_count: got %0d want 1", done_cnt - d0); end
        n_cmp++; if ({b_done_cnt, b_r3} !== {32'd1, 9'd0}) begin n_bad++; $display("FAIL rev_done: got %0d/%0d want 1/0", b_done_cnt, b_r3); end
    endtask

`ifndef SKIP_STOP_EN
    task automatic test_ignore_inputs();
        int d0;
        d0 = done_cnt;
        start(3'd1, 3'd2, 3'd4);
        for (int t = 1; t <= 200; t++) begin
            frame();
            if (t == 10 || t == 110) begin
                start_spin = 1'b0;
                @(negedge clk);
                start_spin = 1'b1;
                f2 = 3'd6;
                @(negedge clk);
            end
            if (t == 60) begin
                n_cmp++; if ({stopped, r1} !== {3'b000, 9'd224}) begin n_bad++; $display("FAIL ign_spin_end: got %b/%0d want 000/224", stopped, r1); end
            end
            if (t == 96) begin
                n_cmp++; if ({stopped, r1} !== {3'b001, 9'd64}) begin n_bad++; $display("FAIL ign_reel1: got %b/%0d want 001/64", stopped, r1); end
            end
            if (t == 144) begin
                n_cmp++; if ({stopped, r2} !== {3'b011, 9'd128}) begin n_bad++; $display("FAIL ign_reel2_latched: got %b/%0d want 011/128", stopped, r2); end
            end
            if (t == 199) begin
                n_cmp++; if (stopped !== 3'b011) begin n_bad++; $display("FAIL ign_reel3_pre: got %b want 011", stopped); end
            end
            if (t == 200) begin
                n_cmp++; if ({stopped, r3} !== {3'b111, 9'd256}) begin n_bad++; $display("FAIL ign_reel3: got %b/%0d want 111/256", stopped, r3); end
            end
        end
        repeat (3) @(negedge clk);
        n_cmp++; if ({busy, 32'(done_cnt - d0)} !== {1'b0, 32'd1}) begin n_bad++; $display("FAIL ign_done: got busy %b count %0d want 0/1", busy, done_cnt - d0); end
    endtask
`else
    task automatic test_skip_stop();
        do_reset();
        start(3'd3, 3'd5, 3'd0);
        repeat (85) frame();
        n_cmp++; if (stopped !== 3'b001) begin n_bad++; $display("FAIL skip_pre: got %b want 001", stopped); end
        start_spin = 1'b0;
        @(negedge clk);
        start_spin = 1'b1;
        @(negedge clk);
        n_cmp++; if ({r1, r2, r3} !== {9'd192, 9'd320, 9'd0}) begin n_bad++; $display("FAIL skip_snap: got %0d/%0d/%0d want 192/320/0", r1, r2, r3); end
        n_cmp++; if ({stopped, done} !== 4'b1111) begin n_bad++; $display("FAIL skip_done: got %b want 1111", {stopped, done}); end
        @(negedge clk);
        n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL skip_after: got %b want 00", {busy, done}); end
    endtask
`endif

    task automatic test_reset_mid();
        int d0;
        do_reset();
        d0 = done_cnt;
        start(3'd2, 3'd1, 3'd7);
        for (int t = 1; t <= 80; t++) begin
            frame();
            if (t == 72) begin
                n_cmp++; if ({stopped, r1} !== {3'b001, 9'd128}) begin n_bad++; $display("FAIL mid_reel1: got %b/%0d want 001/128", stopped, r1); end
            end
        end
        reset = 1'b1; start_spin = 1'b0;
        @(negedge clk);
        n_cmp++; if ({r1, r2, r3} !== 27'd0) begin n_bad++; $display("FAIL mid_offsets: got %0d/%0d/%0d want 0/0/0", r1, r2, r3); end
        n_cmp++; if ({busy, done, stopped} !== 5'b00111) begin n_bad++; $display("FAIL mid_status: got %b want 00111", {busy, done, stopped}); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL mid_no_done: got %0d want 0", done_cnt - d0); end
    endtask

    task automatic test_clamp();
        int d0;
        d0 = done_cnt;
        start(3'd2, 3'd1, 3'd7);
        for (int t = 1; t <= 168; t++) begin
            frame();
            if (t == 120) begin
                n_cmp++; if ({stopped, r2} !== {3'b011, 9'd64}) begin n_bad++; $display("FAIL clamp_reel2: got %b/%0d want 011/64", stopped, r2); end
            end
            if (t == 167) begin
                n_cmp++; if ({stopped, r3} !== {3'b011, 9'd440}) begin n_bad++; $display("FAIL clamp_pre: got %b/%0d want 011/440", stopped, r3); end
            end
            if (t == 168) begin
                n_cmp++; if ({stopped, r1, r2, r3} !== {3'b111, 9'd128, 9'd64, 9'd0}) begin n_bad++; $display("FAIL clamp_final: got %b/%0d/%0d/%0d want 111/128/64/0", stopped, r1, r2, r3); end
            end
        end
        repeat (3) @(negedge clk);
        n_cmp++; if ({busy, 32'(done_cnt - d0)} !== {1'b0, 32'd1}) begin n_bad++; $display("FAIL clamp_done: got busy %b count %0d want 0/1", busy, done_cnt - d0); end
    endtask

    initial begin
        reset = 1'b1; vsync = 1'b1; start_spin = 1'b0;
        test_reset();
        test_full_spin();
`ifdef SKIP_STOP_EN
        test_skip_stop();
`else
        test_ignore_inputs();
`endif
        test_reset_mid();
        test_clamp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
